// File: rtl/calc_pkg.sv
// Shared key codes, operation and state encodings for the keypad calculator.
package calc_pkg;

  localparam logic [4:0] T_0       = 5'd0;
  localparam logic [4:0] T_1       = 5'd1;
  localparam logic [4:0] T_2       = 5'd2;
  localparam logic [4:0] T_3       = 5'd3;
  localparam logic [4:0] T_4       = 5'd4;
  localparam logic [4:0] T_5       = 5'd5;
  localparam logic [4:0] T_6       = 5'd6;
  localparam logic [4:0] T_7       = 5'd7;
  localparam logic [4:0] T_8       = 5'd8;
  localparam logic [4:0] T_9       = 5'd9;
  localparam logic [4:0] T_A       = 5'd10;
  localparam logic [4:0] T_B       = 5'd11;
  localparam logic [4:0] T_C       = 5'd12;
  localparam logic [4:0] T_D       = 5'd13;
  localparam logic [4:0] T_ASTE    = 5'd14;
  localparam logic [4:0] T_HASH    = 5'd15;
  localparam logic [4:0] T_NENHUMA = 5'd31;

  typedef enum logic [1:0] {
    OP_SUM = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2
  } op_t;

  typedef enum logic [1:0] {
    ENTRA_A = 2'd0,
    ENTRA_B = 2'd1,
    CALCULA = 2'd2,
    MOSTRA  = 2'd3
  } estado_t;

endpackage

// File: rtl/calculadora_seq_mult.sv
// Radix-2 shift-add multiplier; bit 0 is folded into the load cycle so the
// product is ready LARGURA-1 cycles after inicio, flagged by a one-cycle pronto.
module mult_seq #(
  parameter int LARGURA = 7
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inicio,
  input  logic [LARGURA-1:0]     a,
  input  logic [LARGURA-1:0]     b,
  output logic [2*LARGURA-1:0]   produto,
  output logic                   pronto
);

  localparam int CW = $clog2(LARGURA + 1);

  logic [2*LARGURA-1:0] acc_q, acc_d;
  logic [2*LARGURA-1:0] mcand_q, mcand_d;
  logic [LARGURA-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 pronto_q, pronto_d;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    pronto_d = 1'b0;
    if (inicio) begin
      acc_d    = b[0] ? {{LARGURA{1'b0}}, a} : '0;
      mcand_d  = {{LARGURA{1'b0}}, a} << 1;
      mplier_d = b >> 1;
      cnt_d    = CW'(LARGURA - 1);
      busy_d   = (LARGURA > 1);
      pronto_d = (LARGURA == 1);
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d   = 1'b0;
        pronto_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      pronto_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      pronto_q <= pronto_d;
    end
  end

  assign produto = acc_q;
  assign pronto  = pronto_q;

endmodule

// File: rtl/calculadora_seq.sv
// Multi-digit keypad calculator: operand entry, sum/sub/mul and display status.
//   state   | meaning
//   ENTRA_A | collecting digits of operand A
//   ENTRA_B | collecting digits of operand B
//   CALCULA | operation in flight, key presses discarded
//   MOSTRA  | result held on the display
module calculadora_seq
  import calc_pkg::*;
#(
  parameter int LARGURA = 7,
  parameter int DIGITOS = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ativo,
  input  logic [4:0]             tecla_atual,
  output logic [LARGURA-1:0]     A,
  output logic [LARGURA-1:0]     B,
  output logic [2*LARGURA-1:0]   resultado,
  output logic                   sinal,
  output logic                   valido,
  output logic                   ocupado,
  output logic                   num_selec
);

  localparam int CW = $clog2(DIGITOS + 1);
  localparam int XW = LARGURA + 4;
  localparam logic [XW-1:0] MAX_V = XW'((1 << LARGURA) - 1);

  estado_t              estado_q, estado_d;
  op_t                  op_q, op_d;
  logic [4:0]           tecla_q;
  logic [LARGURA-1:0]   a_q, a_d, b_q, b_d;
  logic [CW-1:0]        na_q, na_d, nb_q, nb_d;
  logic [2*LARGURA-1:0] res_q, res_d;
  logic                 sinal_q, sinal_d;
  logic                 valido_q, valido_d;
  logic                 ocupado_q, ocupado_d;
  logic                 sel_q, sel_d;

  logic                 press, eh_dig, a_ok, b_ok, mult_inicio, pronto;
  logic [3:0]           dig;
  logic [XW-1:0]        a_ext, b_ext;
  logic [2*LARGURA-1:0] produto;

  // A press is the NENHUMA -> key edge; tracking runs even while ativo is low.
  assign press  = ativo && (tecla_atual != T_NENHUMA) && (tecla_q == T_NENHUMA)
                  && (estado_q != CALCULA);
  assign eh_dig = (tecla_atual <= T_9);
  assign dig    = tecla_atual[3:0];
  assign a_ext  = {4'b0000, a_q} * XW'(10) + XW'(dig);
  assign b_ext  = {4'b0000, b_q} * XW'(10) + XW'(dig);
  assign a_ok   = (na_q < CW'(DIGITOS)) && (a_ext <= MAX_V);
  assign b_ok   = (nb_q < CW'(DIGITOS)) && (b_ext <= MAX_V);
  assign mult_inicio = press && (estado_q == ENTRA_B) && (tecla_atual == T_HASH)
                       && (op_q == OP_MUL);

  mult_seq #(.LARGURA(LARGURA)) u_mult (
    .clk     (clk),
    .reset   (reset),
    .inicio  (mult_inicio),
    .a       (a_q),
    .b       (b_q),
    .produto (produto),
    .pronto  (pronto)
  );

  always_comb begin
    estado_d  = estado_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    na_d      = na_q;
    nb_d      = nb_q;
    res_d     = res_q;
    sinal_d   = sinal_q;
    valido_d  = valido_q;
    ocupado_d = ocupado_q;
    sel_d     = sel_q;

    if (press) begin
      case (tecla_atual)
        T_D: begin
          a_d      = '0;
          b_d      = '0;
          na_d     = '0;
          nb_d     = '0;
          res_d    = '0;
          sinal_d  = 1'b0;
          valido_d = 1'b0;
          sel_d    = 1'b0;
          estado_d = ENTRA_A;
        end
        T_A: op_d = OP_SUM;
        T_B: op_d = OP_SUB;
        T_C: op_d = OP_MUL;
        default: begin
          case (estado_q)
            ENTRA_A: begin
              if (eh_dig) begin
                if (a_ok) begin
                  a_d  = a_ext[LARGURA-1:0];
                  na_d = na_q + CW'(1);
                end
              end else if (tecla_atual == T_ASTE) begin
                b_d      = '0;
                nb_d     = '0;
                sel_d    = 1'b1;
                estado_d = ENTRA_B;
              end
            end
            ENTRA_B: begin
              if (eh_dig) begin
                if (b_ok) begin
                  b_d  = b_ext[LARGURA-1:0];
                  nb_d = nb_q + CW'(1);
                end
              end else if (tecla_atual == T_HASH) begin
                valido_d  = 1'b0;
                ocupado_d = (op_q == OP_MUL);
                estado_d  = CALCULA;
              end
            end
            MOSTRA: begin
              if (eh_dig) begin
                a_d      = LARGURA'(dig);
                na_d     = CW'(1);
                b_d      = '0;
                valido_d = 1'b0;
                sel_d    = 1'b0;
                estado_d = ENTRA_A;
              end else if (tecla_atual == T_ASTE) begin
                b_d      = '0;
                nb_d     = '0;
                valido_d = 1'b0;
                sel_d    = 1'b1;
                estado_d = ENTRA_B;
              end
            end
            default: ;
          endcase
        end
      endcase
    end

    if (estado_q == CALCULA) begin
      case (op_q)
        OP_SUM: begin
          res_d    = {{LARGURA{1'b0}}, a_q} + {{LARGURA{1'b0}}, b_q};
          sinal_d  = 1'b0;
          valido_d = 1'b1;
          estado_d = MOSTRA;
        end
        OP_SUB: begin
          if (b_q > a_q) begin
            res_d   = {{LARGURA{1'b0}}, b_q - a_q};
            sinal_d = 1'b1;
          end else begin
            res_d   = {{LARGURA{1'b0}}, a_q - b_q};
            sinal_d = 1'b0;
          end
          valido_d = 1'b1;
          estado_d = MOSTRA;
        end
        OP_MUL: begin
          if (pronto) begin
            res_d     = produto;
            sinal_d   = 1'b0;
            valido_d  = 1'b1;
            ocupado_d = 1'b0;
            estado_d  = MOSTRA;
          end
        end
        default: estado_d = MOSTRA;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q  <= ENTRA_A;
      op_q      <= OP_SUM;
      tecla_q   <= T_NENHUMA;
      a_q       <= '0;
      b_q       <= '0;
      na_q      <= '0;
      nb_q      <= '0;
      res_q     <= '0;
      sinal_q   <= 1'b0;
      valido_q  <= 1'b0;
      ocupado_q <= 1'b0;
      sel_q     <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      op_q      <= op_d;
      tecla_q   <= tecla_atual;
      a_q       <= a_d;
      b_q       <= b_d;
      na_q      <= na_d;
      nb_q      <= nb_d;
      res_q     <= res_d;
      sinal_q   <= sinal_d;
      valido_q  <= valido_d;
      ocupado_q <= ocupado_d;
      sel_q     <= sel_d;
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign resultado = res_q;
  assign sinal     = sinal_q;
  assign valido    = valido_q;
  assign ocupado   = ocupado_q;
  assign num_selec = sel_q;

endmodule

// File: doc/calculadora_seq.md
Name: calculadora_seq

Overview:
Parametrised successor to the single-digit keypad calculator.
- Accepts multi-digit decimal operands from the keypad decoder, one action per key press.
- Performs sum, subtract (sign-magnitude) and sequential shift-add multiply.
- Drives operands and result to the display driver, with valid/busy status.

Parameters:
LARGURA, 7, operand width in bits; the result is 2*LARGURA bits wide.
DIGITOS, 2, maximum decimal digits accepted per operand.

Ports:
clk  in  1  system clock; all state changes on its rising edge.
reset  in  1  synchronous, active-high reset.
ativo  in  1  enables key processing; when low, presses are ignored but press tracking continues.
tecla_atual  in  5  key code from the decoder; codes are in the package; T_NENHUMA means no key.
A  out  LARGURA  operand A.
B  out  LARGURA  operand B.
resultado  out  2*LARGURA  result magnitude.
sinal  out  1  1 = result is negative (subtract only).
valido  out  1  resultado/sinal hold a completed operation.
ocupado  out  1  multiply in progress.
num_selec  out  1  0 = editing A, 1 = editing B.

Behaviour:
- Reset values: A=0, B=0, resultado=0, sinal=0, valido=0, ocupado=0, num_selec=0, operation=OP_SUM, state=ENTRA_A, previous-key register=T_NENHUMA.
- Press detection:
  - A press is the cycle where tecla_atual != T_NENHUMA and the previous-key register == T_NENHUMA.
  - The previous-key register samples tecla_atual every cycle, independent of ativo.
  - A held key produces exactly one press.
  - Code changes between two non-NENHUMA values produce no press.
- Presses act only when ativo=1 and state is not CALCULA.
- States: ENTRA_A, ENTRA_B, CALCULA, MOSTRA.
- Digit press (code 0-9) in ENTRA_A / ENTRA_B:
  - Update: X <= X*10 + d.
  - Ignored if the operand already has DIGITOS digits.
  - Ignored if the new value exceeds 2^LARGURA-1.
  - Leading zeros count as digits.
- T_A / T_B / T_C: select OP_SUM / OP_SUB / OP_MUL. Accepted in ENTRA_A, ENTRA_B and MOSTRA. No state change.
- T_ASTE in ENTRA_A: go to ENTRA_B, num_selec=1, B=0, B digit count=0.
- T_HASH in ENTRA_B: go to CALCULA, valido=0.
- T_HASH in ENTRA_A: ignored.
- T_D in any state except CALCULA: clear A, B, both digit counts, resultado, sinal, valido; go to ENTRA_A, num_selec=0. The operation is kept.
- CALCULA:
  - OP_SUM: resultado = A+B, zero-extended; sinal=0. Lands on the cycle after the # press.
  - OP_SUB: if B>A, resultado=B-A and sinal=1; else resultado=A-B and sinal=0. Lands on the cycle after the # press. sinal is recomputed every operation, never sticky.
  - OP_MUL: start the multiplier and set ocupado=1. Result lands exactly LARGURA+1 cycles after the # press; ocupado clears in that same cycle. sinal=0.
  - On completion: valido=1 and go to MOSTRA.
- MOSTRA:
  - Digit press: A=d, A digit count=1, B=0, valido=0, num_selec=0, go to ENTRA_A.
  - T_ASTE: chain from the previous operands; go to ENTRA_B with A unchanged, B cleared, valido=0.
- Reset mid-multiply: all registers return to reset values on the next edge; no late result appears.
- Key presses during CALCULA are discarded, not queued.

Decomposition:
- Package calc_pkg:
  - Key codes: T_0..T_9 = 0..9, T_A=10, T_B=11, T_C=12, T_D=13, T_ASTE=14, T_HASH=15, T_NENHUMA=31.
  - Operation enum: OP_SUM=0, OP_SUB=1, OP_MUL=2.
  - State enum.
- Sub-module mult_seq:
  - Parameter LARGURA.
  - Ports clk, reset, inicio, a, b, produto, pronto.
  - Radix-2 shift-add, one bit per cycle.
  - pronto is a one-cycle pulse.

Test Plan (LARGURA=7, DIGITOS=2 unless noted):
- Keys 1,2,*,3,4,C,#, each held 3 cycles with NENHUMA between -> A=12, B=34; 8 cycles after the # press, resultado=408, valido=1. ocupado is high for the 7 cycles before that.
- B,5,*,9,# -> resultado=4, sinal=1. Then digit 9, *, 5, # -> resultado=4, sinal=0.
- Keys 1,2,3 -> A=12 (third digit ignored). DIGITOS=3 build: 1,5,0 -> A=15 (150>127 ignored).
- Hold key 7 for 10 cycles with ativo=1 -> A=7, exactly one press. Press 3 while ativo=0 -> A unchanged.
- Start 99*99 multiply; assert reset 3 cycles later -> next edge all outputs 0, state ENTRA_A; no valido pulse afterwards.
- After a result, press D -> A=B=resultado=0, valido=0, num_selec=0; the operation is unchanged.
